// File: rtl/rtc_i2c_if.sv
// Request/response bus between the RTC scheduler and the byte-oriented I2C master.
// Handshake: the requester raises i2c_start with counts/data stable and holds it until the
// master drops i2c_ready (accept); the master raises i2c_ready again when done, with
// i2c_timeout and i2c_bytes_to_read valid while ready stays high.
interface rtc_i2c_if;
  logic        i2c_start;
  logic [6:0]  i2c_address;
  logic [2:0]  i2c_nr_of_bytes_to_send;
  logic [31:0] i2c_bytes_to_send;
  logic [2:0]  i2c_nr_of_bytes_to_read;
  logic [23:0] i2c_bytes_to_read;
  logic        i2c_ready;
  logic        i2c_timeout;

  modport master (
    output i2c_start, i2c_address, i2c_nr_of_bytes_to_send, i2c_bytes_to_send,
           i2c_nr_of_bytes_to_read,
    input  i2c_bytes_to_read, i2c_ready, i2c_timeout
  );

  modport slave (
    input  i2c_start, i2c_address, i2c_nr_of_bytes_to_send, i2c_bytes_to_send,
           i2c_nr_of_bytes_to_read,
    output i2c_bytes_to_read, i2c_ready, i2c_timeout
  );
endinterface

// File: rtl/rtc_i2c_scheduler.sv
// Schedules periodic DS1307 time reads and user set-time writes over the I2C master,
// retrying transactions that end in a clock-stretch timeout.
module rtc_i2c_scheduler #(
  parameter int         ClockFrequency = 1000000,
  parameter int         PollPeriodMs   = 500,
  parameter logic [6:0] RtcAddress     = 7'h68,
  parameter int         MaxRetries     = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_request,
  input  logic [7:0] set_seconds,
  input  logic [7:0] set_minutes,
  input  logic [7:0] set_hours,
  output logic       set_ack,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic [7:0] hours,
  output logic       time_valid,
  output logic       error,
  output logic [2:0] debug_state,
  rtc_i2c_if.master  i2c
);
  localparam int PollCycles = ClockFrequency / 1000 * PollPeriodMs;
  localparam int TW = (PollCycles > 1) ? $clog2(PollCycles) : 1;
  localparam logic [TW-1:0] TimerLast = TW'(PollCycles - 1);
  localparam int RW = $clog2(MaxRetries + 2);
  localparam logic [RW-1:0] RetryLimit = RW'(MaxRetries);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LAUNCH      = 3'd1,
    WAIT_ACCEPT = 3'd2,
    WAIT_DONE   = 3'd3,
    CHECK       = 3'd4
  } state_t;

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry_cnt;
  logic          poll_pending, set_pending, is_write;
  logic [7:0]    sh_seconds, sh_minutes, sh_hours;
  logic [2:0]    nr_send, nr_read;
  logic [31:0]   send_bytes;
  logic          load_write, load_read, retry, fail, done_ok, start;
  logic          poll_expire;

  assign poll_expire                 = (timer == TimerLast);
  assign debug_state                 = state;
  assign i2c.i2c_start               = start;
  assign i2c.i2c_address             = RtcAddress;
  assign i2c.i2c_nr_of_bytes_to_send = nr_send;
  assign i2c.i2c_bytes_to_send       = send_bytes;
  assign i2c.i2c_nr_of_bytes_to_read = nr_read;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    load_write = 1'b0;
    load_read  = 1'b0;
    retry      = 1'b0;
    fail       = 1'b0;
    done_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (set_pending) begin
          load_write = 1'b1;
          next_state = LAUNCH;
        end else if (poll_pending) begin
          load_read  = 1'b1;
          next_state = LAUNCH;
        end
      end
      LAUNCH: begin
        start      = 1'b1;
        next_state = WAIT_ACCEPT;
      end
      // The master samples start only on its slow internal tick, so hold it until accepted.
      WAIT_ACCEPT: begin
        start = 1'b1;
        if (!i2c.i2c_ready) next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i2c.i2c_ready) next_state = CHECK;
      end
      CHECK: begin
        if (i2c.i2c_timeout) begin
          if (retry_cnt < RetryLimit) begin
            retry      = 1'b1;
            next_state = LAUNCH;
          end else begin
            fail       = 1'b1;
            next_state = IDLE;
          end
        end else begin
          done_ok    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer        <= '0;
      poll_pending <= 1'b1;
      set_pending  <= 1'b0;
      sh_seconds   <= '0;
      sh_minutes   <= '0;
      sh_hours     <= '0;
      retry_cnt    <= '0;
      is_write     <= 1'b0;
      nr_send      <= '0;
      send_bytes   <= '0;
      nr_read      <= '0;
      seconds      <= '0;
      minutes      <= '0;
      hours        <= '0;
      time_valid   <= 1'b0;
      error        <= 1'b0;
      set_ack      <= 1'b0;
    end else begin
      timer   <= poll_expire ? '0 : timer + 1'b1;
      set_ack <= done_ok && is_write;

      // A fresh expiry or completed write outranks the clear so no poll is lost.
      if (poll_expire || (done_ok && is_write)) poll_pending <= 1'b1;
      else if (load_read)                        poll_pending <= 1'b0;

      if (set_request) begin
        set_pending <= 1'b1;
        sh_seconds  <= set_seconds;
        sh_minutes  <= set_minutes;
        sh_hours    <= set_hours;
      end else if (load_write) begin
        set_pending <= 1'b0;
      end

      if (load_write) begin
        is_write   <= 1'b1;
        nr_send    <= 3'd4;
        send_bytes <= {sh_hours & 8'h3F, sh_minutes & 8'h7F, sh_seconds & 8'h7F, 8'h00};
        nr_read    <= 3'd0;
      end else if (load_read) begin
        is_write   <= 1'b0;
        nr_send    <= 3'd1;
        send_bytes <= 32'h0;
        nr_read    <= 3'd3;
      end

      if (retry) retry_cnt <= retry_cnt + 1'b1;
      if (fail) begin
        error     <= 1'b1;
        retry_cnt <= '0;
      end
      if (done_ok) begin
        error     <= 1'b0;
        retry_cnt <= '0;
        if (!is_write) begin
          seconds    <= i2c.i2c_bytes_to_read[7:0] & 8'h7F;
          minutes    <= i2c.i2c_bytes_to_read[15:8] & 8'h7F;
          hours      <= i2c.i2c_bytes_to_read[23:16] & 8'h3F;
          time_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rtc_i2c_scheduler.sv
// Bench for rtc_i2c_scheduler: behavioural I2C master, transaction scoreboard,
// set-time vector table and hand-written retry/arbitration/reset sequences.
module tb_rtc_i2c_scheduler;
  localparam int CLK_HZ      = 40000;
  localparam int POLL_MS     = 100;
  localparam int PERIOD      = CLK_HZ / 1000 * POLL_MS;
  localparam int MAX_RETRIES = 3;
  localparam int W           = 38;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       set_request = 1'b0;
  logic [7:0] set_seconds = '0, set_minutes = '0, set_hours = '0;
  logic       set_ack, time_valid, error;
  logic [7:0] seconds, minutes, hours;
  logic [2:0] debug_state;

  rtc_i2c_if bus ();

  rtc_i2c_scheduler #(
    .ClockFrequency(CLK_HZ), .PollPeriodMs(POLL_MS),
    .RtcAddress(7'h68), .MaxRetries(MAX_RETRIES)
  ) dut (
    .clock(clock), .reset(reset),
    .set_request(set_request), .set_seconds(set_seconds),
    .set_minutes(set_minutes), .set_hours(set_hours),
    .set_ack(set_ack), .seconds(seconds), .minutes(minutes), .hours(hours),
    .time_valid(time_valid), .error(error), .debug_state(debug_state),
    .i2c(bus)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clock = ~clock;

  int since_rst = 0;
  always @(posedge clock or posedge reset) begin
    if (reset) since_rst = 0;
    else       since_rst = since_rst + 1;
  end

  int ack_count = 0;
  always @(negedge clock) if (set_ack) ack_count = ack_count + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rd_txn();
    return {3'd1, 32'h0000_0000, 3'd3};
  endfunction

  function automatic logic [W-1:0] wr_txn(input logic [31:0] b);
    return {3'd4, b, 3'd0};
  endfunction

  // ---------------- behavioural I2C master ----------------
  int          accept_delay = 3;
  int          to_remaining = 0;
  int          m_phase = 0;
  int          wait_cnt = 0;
  int          busy = 0;
  logic        held = 1'b1;
  logic [23:0] rd_data = '0;
  logic [W-1:0] got, exp_t;

  initial begin
    bus.i2c_ready         = 1'b1;
    bus.i2c_timeout       = 1'b0;
    bus.i2c_bytes_to_read = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_phase         = 0;
        bus.i2c_ready   = 1'b1;
        bus.i2c_timeout = 1'b0;
      end else begin
        case (m_phase)
          0: if (bus.i2c_start) begin
            wait_cnt = 1;
            held     = 1'b1;
            m_phase  = 1;
          end
          1: begin
            if (!bus.i2c_start) held = 1'b0;
            wait_cnt++;
            if (wait_cnt >= accept_delay) begin
              bus.i2c_ready   = 1'b0;
              bus.i2c_timeout = 1'b0;
              check("start_held", held, 1);
              check("address", bus.i2c_address, 7'h68);
              got = {bus.i2c_nr_of_bytes_to_send,
                     bus.i2c_bytes_to_send & ((bus.i2c_nr_of_bytes_to_send == 3'd1) ? 32'hFF : 32'hFFFF_FFFF),
                     bus.i2c_nr_of_bytes_to_read};
              if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL txn_unexpected actual=%0h expected=none", got);
              end else begin
                exp_t = exp_q.pop_front();
                check("txn", got, exp_t);
              end
              busy    = 0;
              m_phase = 2;
            end
          end
          default: begin
            busy++;
            if (busy == 1) check("start_drop", bus.i2c_start, 0);
            if (busy == 4) begin
              if (to_remaining > 0) begin
                bus.i2c_timeout = 1'b1;
                to_remaining--;
              end else begin
                bus.i2c_timeout = 1'b0;
              end
              bus.i2c_bytes_to_read = rd_data;
              bus.i2c_ready         = 1'b1;
              m_phase               = 0;
            end
          end
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset       = 1'b1;
    set_request = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic pulse_set(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    @(negedge clock);
    set_seconds = s;
    set_minutes = m;
    set_hours   = h;
    set_request = 1'b1;
    @(negedge clock);
    set_request = 1'b0;
  endtask

  // Waits for every queued transaction and then a few idle cycles with nothing launched.
  task automatic wait_quiet(input int budget);
    int n = 0;
    int quiet = 0;
    while ((exp_q.size() != 0 || quiet < 4) && n < budget) begin
      @(negedge clock);
      n++;
      if (exp_q.size() == 0 && m_phase == 0 && bus.i2c_ready && debug_state == 3'd0) quiet++;
      else quiet = 0;
    end
    check("txn_complete", (exp_q.size() == 0 && quiet >= 4), 1);
  endtask

  task automatic check_time(input string name, input logic [7:0] s, input logic [7:0] m,
                            input logic [7:0] h);
    check(name, {seconds, minutes, hours}, {s, m, h});
  endtask

  // ---------------- set-time vector table ----------------
  typedef struct {
    logic [7:0]  s, m, h;
    logic [31:0] exp_bytes;
    logic [23:0] rd;
    logic [7:0]  exp_s, exp_m, exp_h;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int ack0, n;
    vecs[0] = '{8'h30, 8'h15, 8'h12, 32'h1215_3000, 24'h12_15_30, 8'h30, 8'h15, 8'h12};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 32'h3F7F_7F00, 24'hFF_FF_FF, 8'h7F, 8'h7F, 8'h3F};
    vecs[2] = '{8'h80, 8'h00, 8'h23, 32'h2300_0000, 24'hC0_80_80, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'h59, 8'h59, 8'h23, 32'h2359_5900, 24'h23_59_D9, 8'h59, 8'h59, 8'h23};

    // Reset state, then the initial poll READ.
    @(negedge clock);
    check("rst_outs", {set_ack, seconds, minutes, hours, time_valid, error}, 0);
    check("rst_bus", {bus.i2c_start, bus.i2c_nr_of_bytes_to_send, bus.i2c_bytes_to_send,
                      bus.i2c_nr_of_bytes_to_read}, 0);
    check("rst_address", bus.i2c_address, 7'h68);
    rd_data = 24'h23_59_85;
    exp_q.push_back(rd_txn());
    reset = 1'b0;
    wait_quiet(200);
    check_time("first_read", 8'h05, 8'h59, 8'h23);
    check("first_valid", {time_valid, error}, 2'b10);

    // Table: each set-time gives WRITE, set_ack, then an immediate READ.
    for (int i = 0; i < 4; i++) begin
      ack0    = ack_count;
      rd_data = vecs[i].rd;
      exp_q.push_back(wr_txn(vecs[i].exp_bytes));
      exp_q.push_back(rd_txn());
      pulse_set(vecs[i].s, vecs[i].m, vecs[i].h);
      wait_quiet(200);
      check("vec_ack", ack_count - ack0, 1);
      check_time("vec_time", vecs[i].exp_s, vecs[i].exp_m, vecs[i].exp_h);
    end

    // Slow acceptance: start held ~3000 cycles, single transaction.
    do_reset();
    rd_data      = 24'h01_02_03;
    accept_delay = 3000;
    exp_q.push_back(rd_txn());
    wait_quiet(3300);
    accept_delay = 3;
    check_time("slow_read", 8'h03, 8'h02, 8'h01);

    // Four timeouts: four identical launches, error, no ack; next poll recovers.
    do_reset();
    rd_data = 24'h10_20_30;
    exp_q.push_back(rd_txn());
    wait_quiet(200);
    ack0         = ack_count;
    to_remaining = 4;
    for (int k = 0; k < 4; k++) exp_q.push_back(wr_txn(32'h0820_1000));
    pulse_set(8'h10, 8'h20, 8'h08);
    wait_quiet(400);
    check("retry_error", error, 1);
    check("retry_no_ack", ack_count - ack0, 0);
    check_time("retry_hold_time", 8'h30, 8'h20, 8'h10);
    rd_data = 24'h07_06_05;
    exp_q.push_back(rd_txn());
    wait_quiet(PERIOD + 200);
    check("recover_error", {error, time_valid}, 2'b01);
    check_time("recover_time", 8'h05, 8'h06, 8'h07);

    // set_request in the poll-expiry cycle, then a second request during the WRITE.
    do_reset();
    rd_data = 24'h00_00_01;
    exp_q.push_back(rd_txn());
    wait_quiet(200);
    ack0 = ack_count;
    n    = 0;
    while (since_rst != PERIOD - 1 && n < PERIOD + 10) begin
      @(negedge clock);
      n++;
    end
    check("expiry_align", since_rst, PERIOD - 1);
    exp_q.push_back(wr_txn(32'h0922_1100));
    set_seconds = 8'h11;
    set_minutes = 8'h22;
    set_hours   = 8'h09;
    set_request = 1'b1;
    @(negedge clock);
    set_request = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    rd_data = 24'h13_44_33;
    exp_q.push_back(wr_txn(32'h1344_3300));
    exp_q.push_back(rd_txn());
    pulse_set(8'h33, 8'h44, 8'h13);
    wait_quiet(300);
    check("double_write_acks", ack_count - ack0, 2);
    check_time("double_write_time", 8'h33, 8'h44, 8'h13);

    // Reset during WAIT_DONE of a WRITE: async clear, then a READ first.
    ack0 = ack_count;
    exp_q.push_back(wr_txn(32'h0102_0300));
    pulse_set(8'h03, 8'h02, 8'h01);
    n = 0;
    while ((m_phase != 2 || exp_q.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("pre_reset_state", debug_state, 3'd3);
    #2;
    reset = 1'b1;
    #1;
    check("async_start", bus.i2c_start, 0);
    check("async_outs", {set_ack, seconds, minutes, hours, time_valid, error}, 0);
    check("async_bus", {bus.i2c_nr_of_bytes_to_send, bus.i2c_bytes_to_send,
                        bus.i2c_nr_of_bytes_to_read}, 0);
    repeat (2) @(negedge clock);
    rd_data = 24'h21_43_55;
    exp_q.push_back(rd_txn());
    reset = 1'b0;
    wait_quiet(200);
    check("abort_no_ack", ack_count - ack0, 0);
    check_time("post_reset_time", 8'h55, 8'h43, 8'h21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time limit so a stuck DUT still ends in a summary line.
  initial begin
    #2000000;
    failures++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
